// File: rtl/uart_pkg.sv
// Shared types, frame constants and helpers for the buffered UART transmitter.
// UART_TX_PARITY_EN adds an even-parity bit and the PARITY state.
package uart_pkg;

    localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
    localparam int FRAME_BITS = 11;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
    localparam int FRAME_BITS = 10;
`endif

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-write and status bundle of the buffered UART transmitter.
interface uart_tx_fifo_if;
    logic       i_en;
    logic [7:0] i_data;
    logic       o_tx;
    logic       o_busy;
    logic       o_full;
    logic       o_overflow;

    modport master (output i_en, i_data, input o_tx, o_busy, o_full, o_overflow);
    modport slave  (input i_en, i_data, output o_tx, o_busy, o_full, o_overflow);
endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with registered full/empty flags; a push while full is accepted
// only when a pop happens on the same edge.
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign pop_ok_s  = pop && !empty_q;
    assign push_ok_s = push && (!full_q || pop_ok_s);

    // Pointer, occupancy and flag next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == CW'(0));
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is only read behind a valid pop, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 framer (8E1 when
// UART_TX_PARITY_EN is defined). Back-to-back FIFO entries go out gap-free.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave bus
);
    import uart_pkg::*;

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        data_q, data_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              pop_s;
    logic              bit_done_s;
    logic [7:0]        fifo_rdata_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.i_en),
        .pop   (pop_s),
        .wdata (bus.i_data),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign bit_done_s = (cnt_q == CNT_W'(CPB - 1));

    // Framer next-state; the baud counter restarts at every bit boundary.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        pop_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = START;
                    pop_s   = 1'b1;
                    data_d  = fifo_rdata_s;
                    cnt_d   = CNT_W'(0);
                end else begin
                    cnt_d   = CNT_W'(0);
                end
            end
            START: begin
                if (bit_done_s) begin
                    state_d   = DATA;
                    cnt_d     = CNT_W'(0);
                    bit_idx_d = 3'd0;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_done_s) begin
                    cnt_d = CNT_W'(0);
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done_s) begin
                    state_d = STOP;
                    cnt_d   = CNT_W'(0);
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_done_s) begin
                    cnt_d = CNT_W'(0);
                    if (!fifo_empty_s) begin
                        state_d = START;
                        pop_s   = 1'b1;
                        data_d  = fifo_rdata_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_W'(0);
            end
        endcase
    end

    // Line level and status; the line lags the state by one register stage.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = even_parity(data_q);
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != IDLE) || (fifo_count_s != CW'(0)) || bus.i_en;
        ovf_d  = ovf_q || (bus.i_en && fifo_full_s && !pop_s);
    end

    // Framer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_W'(0);
            bit_idx_q <= 3'd0;
            data_q    <= 8'h00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.o_tx       = tx_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_full     = fifo_full_s;
    assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 10 clocks per bit and a 4-entry FIFO.
// Define UART_TX_PARITY_EN for both bench and RTL to cover the parity build.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CPB       = 10;
    localparam int FB        = FRAME_BITS;
    localparam int FRAME_CYC = CPB * FB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLK_FREQ   (50_000_000),
        .BAUD_RATE  (5_000_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected line level for bit position i of a frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        logic r;
        r = 1'b1;
        if (i == 0) r = 1'b0;
        else if (i <= 8) r = b[i-1];
`ifdef UART_TX_PARITY_EN
        else if (i == 9) r = ^b;
`endif
        return r;
    endfunction

    // Checks every cycle of one frame, starting skip cycles into its start bit.
    task automatic check_frame(input logic [7:0] b, input int skip);
        for (int i = 0; i < FB; i++) begin
            for (int c = 0; c < CPB; c++) begin
                if (!(i == 0 && c < skip)) begin
                    check($sformatf("line byte=%h bit=%0d cyc=%0d", b, i, c), bus.o_tx, frame_bit(b, i));
                    check($sformatf("busy_in_frame byte=%h", b), bus.o_busy, 1'b1);
                    tick();
                end
            end
        end
    endtask

    initial begin
        bus.i_en   = 1'b0;
        bus.i_data = 8'h00;
        tick();
        tick();
        check("rst_tx", bus.o_tx, 1'b1);
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_full", bus.o_full, 1'b0);
        check("rst_ovf", bus.o_overflow, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single byte into idle: line drops two edges after the write.
        bus.i_en = 1'b1; bus.i_data = 8'hA5;
        tick();
        bus.i_en = 1'b0;
        check("lat_edge_n", bus.o_tx, 1'b1);
        check("busy_after_write", bus.o_busy, 1'b1);
        tick();
        check("lat_edge_n1", bus.o_tx, 1'b1);
        tick();
        check_frame(8'hA5, 0);
        check("single_busy_end", bus.o_busy, 1'b0);
        check("single_tx_end", bus.o_tx, 1'b1);
        repeat (5) tick();
        check("idle_tx", bus.o_tx, 1'b1);
        check("idle_busy", bus.o_busy, 1'b0);

        // Two-byte burst: frames must be back to back.
        bus.i_en = 1'b1; bus.i_data = 8'h12;
        tick();
        bus.i_data = 8'h34;
        tick();
        bus.i_en = 1'b0;
        tick();
        check_frame(8'h12, 0);
        check_frame(8'h34, 0);
        check("burst_busy_end", bus.o_busy, 1'b0);

        // Six writes into a 4-deep FIFO: the sixth is dropped.
        for (int k = 1; k <= 6; k++) begin
            bus.i_en = 1'b1; bus.i_data = 8'(k);
            if (k == 5) check("full_before_5th", bus.o_full, 1'b0);
            if (k == 6) check("full_at_6th", bus.o_full, 1'b1);
            tick();
        end
        bus.i_en = 1'b0;
        check("ovf_set", bus.o_overflow, 1'b1);
        check("full_after_drop", bus.o_full, 1'b1);
        check_frame(8'h01, 3);
        check_frame(8'h02, 0);
        check_frame(8'h03, 0);
        check_frame(8'h04, 0);
        check_frame(8'h05, 0);
        check("ovf_busy_end", bus.o_busy, 1'b0);
        check("ovf_full_end", bus.o_full, 1'b0);
        repeat (20) tick();
        check("dropped_not_sent_tx", bus.o_tx, 1'b1);
        check("dropped_not_sent_busy", bus.o_busy, 1'b0);
        check("ovf_sticky", bus.o_overflow, 1'b1);

`ifdef UART_TX_PARITY_EN
        bus.i_en = 1'b1; bus.i_data = 8'h07;
        tick();
        bus.i_en = 1'b0;
        tick();
        tick();
        check_frame(8'h07, 0);
        check("parity_busy_end", bus.o_busy, 1'b0);
`endif

        // Reset during data bit 3 of 0x55 with two bytes queued.
        bus.i_en = 1'b1; bus.i_data = 8'h55;
        tick();
        bus.i_data = 8'h66;
        tick();
        bus.i_data = 8'h77;
        tick();
        bus.i_en = 1'b0;
        repeat (44) tick();
        check("pre_rst_bit3", bus.o_tx, 1'b0);
        check("pre_rst_ovf", bus.o_overflow, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", bus.o_tx, 1'b1);
        check("midrst_busy", bus.o_busy, 1'b0);
        check("midrst_full", bus.o_full, 1'b0);
        check("midrst_ovf", bus.o_overflow, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            repeat (10) tick();
            check("post_rst_tx", bus.o_tx, 1'b1);
            check("post_rst_busy", bus.o_busy, 1'b0);
        end
        bus.i_en = 1'b1; bus.i_data = 8'h3C;
        tick();
        bus.i_en = 1'b0;
        tick();
        tick();
        check_frame(8'h3C, 0);
        check("post_rst_frame_end", bus.o_busy, 1'b0);

        // Write on the pop edge while full: accepted, no overflow.
        for (int k = 0; k < 5; k++) begin
            bus.i_en = 1'b1; bus.i_data = 8'hA1 + 8'(k);
            tick();
        end
        bus.i_en = 1'b0;
        check("simul_full_pre", bus.o_full, 1'b1);
        check("simul_ovf_pre", bus.o_overflow, 1'b0);
        repeat (FRAME_CYC - 4) tick();
        check("simul_full_edge_m1", bus.o_full, 1'b1);
        bus.i_en = 1'b1; bus.i_data = 8'hA6;
        tick();
        bus.i_en = 1'b0;
        check("simul_full_after", bus.o_full, 1'b1);
        check("simul_ovf_after", bus.o_overflow, 1'b0);
        check("simul_stop_last", bus.o_tx, 1'b1);
        tick();
        check_frame(8'hA2, 0);
        check_frame(8'hA3, 0);
        check_frame(8'hA4, 0);
        check_frame(8'hA5, 0);
        check_frame(8'hA6, 0);
        check("simul_busy_end", bus.o_busy, 1'b0);
        check("simul_ovf_end", bus.o_overflow, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_FREQ, 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, 115200, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, 16, byte buffer depth; power of two, minimum 2.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_en  input  1  byte write strobe; may be high on consecutive cycles.
REQ-007 i_data  input  8  byte to send, sampled when i_en=1.
REQ-008 o_tx  output  1  UART serial line, registered, idle high.
REQ-009 o_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-010 o_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 o_overflow  output  1  sticky; a write was dropped.

Function
REQ-012 The block SHALL accept one byte per cycle, so that back-to-back strobes such as a high-byte-then-low-byte burst are absorbed without loss.
REQ-013 CLKS_PER_BIT SHALL equal CLK_FREQ/BAUD_RATE (integer division); each line bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-014 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, optional parity (REQ-026), and 1 stop bit (1).
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
- IDLE->START when the FIFO is non-empty; the byte is popped on the same edge.
- START->DATA after one bit time.
- DATA->PARITY or STOP after 8 bit times; bit index 0..7.
- PARITY->STOP after one bit time.
- STOP->START directly if the FIFO is non-empty (pop on the same edge), else STOP->IDLE.
REQ-016 Latency: for a write at edge N into an empty FIFO with the FSM in IDLE, o_tx SHALL go low after edge N+2.
REQ-017 Frames from consecutive FIFO entries SHALL be contiguous, with no idle cycles between a stop bit and the next start bit.
REQ-018 Write when full: the byte SHALL be dropped, o_overflow SHALL be set, and FIFO contents SHALL be unchanged.
REQ-019 Simultaneous write and pop when full: the write SHALL be accepted, occupancy SHALL be unchanged, and o_overflow SHALL NOT be set.
REQ-020 Simultaneous write and pop when empty is not possible; the pop requires a non-empty FIFO at the prior edge.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use a log2(FIFO_DEPTH)+1-bit count.
REQ-022 o_overflow SHALL clear only on reset.
REQ-023 The baud counter SHALL reload at every state transition; there SHALL be no fractional-rate accumulation.

Reset
REQ-024 Asserting rst_n low SHALL immediately set: o_tx=1, o_busy=0, o_full=0, o_overflow=0, FSM=IDLE, FIFO empty, all counters 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame, drive o_tx high at once and discard all buffered bytes; transmission SHALL resume only on new writes.

Configuration
REQ-026 Macro UART_TX_PARITY_EN:
- Defined: an even-parity bit (XOR of the 8 data bits) SHALL be sent in PARITY; frame is 11 bits.
- Undefined: the PARITY state and its logic SHALL be absent; frame is 10 bits.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state enum, the frame bit-count constants, and a function computing CLKS_PER_BIT.
REQ-028 The FIFO SHALL be a sub-module uart_byte_fifo (push, pop, data, full, empty, count); the FSM and baud counter stay in uart_tx_fifo.

Verification (CLK_FREQ=50_000_000, BAUD_RATE=5_000_000, so 10 clocks/bit; FIFO_DEPTH=4)
REQ-029 Single byte 0xA5 into idle -> o_tx low 2 edges later; line sequence 0,1,0,1,0,0,1,0,1,1 at 10 clocks each; o_busy falls after the stop bit.
REQ-030 Burst 0x12 then 0x34 on consecutive cycles -> two contiguous frames, 0x12 first, 200 cycles total, no gap.
REQ-031 6 writes 0x01..0x06 on consecutive cycles into empty idle -> 0x01 popped at the second edge; 0x01..0x05 transmitted; 0x06 dropped; o_full=1 during the 0x06 write; o_overflow=1 and stays set.
REQ-032 With UART_TX_PARITY_EN, 0xA5 -> parity bit 0; 0x07 -> parity bit 1; frame is 110 cycles.
REQ-033 rst_n low at data bit 3 of 0x55 with 2 bytes queued -> o_tx=1 immediately, all flags 0; after release, no frame is sent until a new write.
REQ-034 Write on the exact edge the FSM pops while full -> occupancy stays 4, o_overflow stays 0, and all bytes are sent in order.
